// File: rtl/team_06_prog_clkdiv.sv
// team_06_prog_clkdiv: multi-channel run-time programmable clock divider / tick generator.
// Each channel produces a square-wave enable clock, a registered rising-edge tick and a
// one-shot completion flag. Divisors written while a channel runs take effect at its next wrap.
// Optional macro TEAM_06_CLKDIV_SYNC_EN adds a 'sync' input that phase-aligns all enabled channels.
module team_06_prog_clkdiv #(
    parameter int NCH         = 2,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1,
    localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_wr,
    input  logic [SELW-1:0]  cfg_sel,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_oneshot,
`ifdef TEAM_06_CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   done
);

    logic sel_valid;
    logic sync_hit;

    // Writes addressing a channel that does not exist are dropped here.
    assign sel_valid = cfg_wr && (int'(cfg_sel) < NCH);

`ifdef TEAM_06_CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    genvar i;
    for (i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] counter, counter_n;
        logic [WIDTH-1:0] active_div, active_div_n;
        logic [WIDTH-1:0] pend_div, pend_div_n;
        logic             oneshot, oneshot_n;
        logic             pend_os, pend_os_n;
        logic             pend_valid, pend_valid_n;
        logic             clk_q, clk_n;
        logic             tick_q, tick_n;
        logic             done_q, done_n;
        logic             wr_here;

        assign wr_here = sel_valid && (cfg_sel == SELW'(i));

        // Next-state for one channel: idle/realign, one-shot count, free-run count, then config write.
        always_comb begin
            counter_n    = counter;
            active_div_n = active_div;
            pend_div_n   = pend_div;
            oneshot_n    = oneshot;
            pend_os_n    = pend_os;
            pend_valid_n = pend_valid;
            clk_n        = clk_q;
            tick_n       = 1'b0;
            done_n       = done_q;

            if (!en[i] || sync_hit) begin
                counter_n = '0;
                clk_n     = 1'b0;
                done_n    = 1'b0;
                if (pend_valid) begin
                    active_div_n = pend_div;
                    oneshot_n    = pend_os;
                    pend_valid_n = 1'b0;
                end
            end else if (oneshot) begin
                clk_n = 1'b0;
                if (done_q) begin
                    if (pend_valid) begin
                        active_div_n = pend_div;
                        oneshot_n    = pend_os;
                        pend_valid_n = 1'b0;
                        counter_n    = '0;
                        done_n       = 1'b0;
                    end
                end else if (counter == active_div) begin
                    tick_n = 1'b1;
                    done_n = 1'b1;
                end else begin
                    counter_n = counter + WIDTH'(1);
                end
            end else begin
                if (counter == active_div) begin
                    counter_n = '0;
                    if (pend_valid) begin
                        active_div_n = pend_div;
                        oneshot_n    = pend_os;
                        pend_valid_n = 1'b0;
                    end
                    if (oneshot_n) begin
                        clk_n = 1'b0;
                    end else begin
                        clk_n  = ~clk_q;
                        tick_n = ~clk_q;
                    end
                end else begin
                    counter_n = counter + WIDTH'(1);
                end
            end

            if (wr_here) begin
                if (en[i]) begin
                    pend_div_n   = cfg_div;
                    pend_os_n    = cfg_oneshot;
                    pend_valid_n = 1'b1;
                end else begin
                    active_div_n = cfg_div;
                    oneshot_n    = cfg_oneshot;
                    pend_valid_n = 1'b0;
                end
            end
        end

        // Channel state register; everything returns to defaults on rst without a clock.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                counter    <= '0;
                active_div <= WIDTH'(DEFAULT_DIV);
                pend_div   <= WIDTH'(DEFAULT_DIV);
                oneshot    <= 1'b0;
                pend_os    <= 1'b0;
                pend_valid <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                counter    <= counter_n;
                active_div <= active_div_n;
                pend_div   <= pend_div_n;
                oneshot    <= oneshot_n;
                pend_os    <= pend_os_n;
                pend_valid <= pend_valid_n;
                clk_q      <= clk_n;
                tick_q     <= tick_n;
                done_q     <= done_n;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign done[i]    = done_q;
    end

endmodule

// File: tb/tb_team_06_prog_clkdiv.sv
// tb_team_06_prog_clkdiv: directed and randomized checks of the programmable divider against
// a segment-based arithmetic reference model of the channel timing rules.
module tb_team_06_prog_clkdiv;

    localparam int NCH   = 3;
    localparam int WIDTH = 8;
    localparam int DDIV  = 1;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             cfg_wr;
    logic [1:0]       cfg_sel;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_oneshot;
`ifdef TEAM_06_CLKDIV_SYNC_EN
    logic             sync;
`endif
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   done;

    int checks;
    int failures;

    // Reference model: each channel remembers the edge where its current timing segment started,
    // the output level at that point and its active/pending configuration.
    int       k;
    int       seg_k   [NCH];
    bit       seg_lvl [NCH];
    int       m_div   [NCH];
    bit       m_os    [NCH];
    int       m_pdiv  [NCH];
    bit       m_pos   [NCH];
    bit       m_pv    [NCH];
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_done;

    team_06_prog_clkdiv #(
        .NCH(NCH),
        .WIDTH(WIDTH),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_wr(cfg_wr),
        .cfg_sel(cfg_sel),
        .cfg_div(cfg_div),
        .cfg_oneshot(cfg_oneshot),
`ifdef TEAM_06_CLKDIV_SYNC_EN
        .sync(sync),
`endif
        .clk_out(clk_out),
        .tick(tick),
        .done(done)
    );

    // Free-running 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        k = 0;
        for (int c = 0; c < NCH; c++) begin
            seg_k[c]   = 0;
            seg_lvl[c] = 1'b0;
            m_div[c]   = DDIV;
            m_os[c]    = 1'b0;
            m_pdiv[c]  = DDIV;
            m_pos[c]   = 1'b0;
            m_pv[c]    = 1'b0;
        end
        exp_clk  = '0;
        exp_tick = '0;
        exp_done = '0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        k++;
        for (int c = 0; c < NCH; c++) begin
            bit wr_here;
            int n;
            int half;
            bit lvl;
            wr_here = cfg_wr && (int'(cfg_sel) == c);
            n       = k - seg_k[c];
            half    = m_div[c] + 1;
            if (!en[c]) begin
                seg_k[c]   = k;
                seg_lvl[c] = 1'b0;
                if (m_pv[c]) begin
                    m_div[c] = m_pdiv[c];
                    m_os[c]  = m_pos[c];
                    m_pv[c]  = 1'b0;
                end
                exp_clk[c]  = 1'b0;
                exp_tick[c] = 1'b0;
                exp_done[c] = 1'b0;
                if (wr_here) begin
                    m_div[c] = int'(cfg_div);
                    m_os[c]  = cfg_oneshot;
                    m_pv[c]  = 1'b0;
                end
            end else if (m_os[c]) begin
                exp_clk[c] = 1'b0;
                if (n > half && m_pv[c]) begin
                    m_div[c]    = m_pdiv[c];
                    m_os[c]     = m_pos[c];
                    m_pv[c]     = 1'b0;
                    seg_k[c]    = k;
                    seg_lvl[c]  = 1'b0;
                    exp_tick[c] = 1'b0;
                    exp_done[c] = 1'b0;
                end else begin
                    exp_tick[c] = (n == half);
                    exp_done[c] = (n >= half);
                end
                if (wr_here) begin
                    m_pdiv[c] = int'(cfg_div);
                    m_pos[c]  = cfg_oneshot;
                    m_pv[c]   = 1'b1;
                end
            end else begin
                lvl         = seg_lvl[c] ^ bit'((n / half) % 2);
                exp_clk[c]  = lvl;
                exp_tick[c] = ((n % half) == 0) && lvl;
                exp_done[c] = 1'b0;
                if (((n % half) == 0) && m_pv[c]) begin
                    m_div[c]   = m_pdiv[c];
                    m_os[c]    = m_pos[c];
                    m_pv[c]    = 1'b0;
                    seg_k[c]   = k;
                    seg_lvl[c] = lvl;
                    if (m_os[c]) begin
                        seg_lvl[c]  = 1'b0;
                        exp_clk[c]  = 1'b0;
                        exp_tick[c] = 1'b0;
                    end
                end
                if (wr_here) begin
                    m_pdiv[c] = int'(cfg_div);
                    m_pos[c]  = cfg_oneshot;
                    m_pv[c]   = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (clk_out === exp_clk) else begin
            failures++;
            $error("[TB] FAIL %s clk_out k=%0d got=%b exp=%b", tag, k, clk_out, exp_clk);
        end
        checks++;
        assert (tick === exp_tick) else begin
            failures++;
            $error("[TB] FAIL %s tick k=%0d got=%b exp=%b", tag, k, tick, exp_tick);
        end
        checks++;
        assert (done === exp_done) else begin
            failures++;
            $error("[TB] FAIL %s done k=%0d got=%b exp=%b", tag, k, done, exp_done);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model.
    task automatic applyStimulus(input logic [NCH-1:0] en_v, input logic wr_v,
                                 input logic [1:0] sel_v, input logic [WIDTH-1:0] div_v,
                                 input logic os_v, input string tag);
        en          = en_v;
        cfg_wr      = wr_v;
        cfg_sel     = sel_v;
        cfg_div     = div_v;
        cfg_oneshot = os_v;
        @(posedge clk);
        model_edge();
        #1;
        checkOutput(tag);
    endtask

    task automatic run(input int cycles, input string tag);
        for (int j = 0; j < cycles; j++)
            applyStimulus(en, 1'b0, 2'd0, '0, 1'b0, tag);
    endtask

    // Asynchronous reset pulse starting between edges and held across one edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        checkOutput("reset_async");
        @(posedge clk);
        #1;
        checkOutput("reset_held");
        #2 rst = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        en          = '0;
        cfg_wr      = 1'b0;
        cfg_sel     = '0;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;
`ifdef TEAM_06_CLKDIV_SYNC_EN
        sync        = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_init");
        rst = 1'b0;

        $display("[TB] default divisor, reset mid-count");
        applyStimulus(3'b001, 1'b0, 2'd0, '0, 1'b0, "default");
        run(6, "default");
        pulse_reset();
        run(12, "default_after_rst");

        $display("[TB] free-run div=2 programmed while disabled");
        applyStimulus(3'b000, 1'b1, 2'd0, 8'd2, 1'b0, "div2_cfg");
        applyStimulus(3'b001, 1'b0, 2'd0, '0, 1'b0, "div2");
        run(13, "div2");

        $display("[TB] glitch-free update to div=0 mid half-period");
        applyStimulus(3'b001, 1'b1, 2'd0, 8'd0, 1'b0, "div0_wr");
        run(10, "div0");

        $display("[TB] one-shot on channel 1");
        applyStimulus(3'b001, 1'b1, 2'd1, 8'd3, 1'b1, "os_cfg");
        applyStimulus(3'b011, 1'b0, 2'd0, '0, 1'b0, "oneshot");
        run(7, "oneshot");
        applyStimulus(3'b011, 1'b1, 2'd1, 8'd2, 1'b1, "os_rewrite");
        run(6, "oneshot_restart");
        applyStimulus(3'b001, 1'b0, 2'd0, '0, 1'b0, "os_drop");
        run(2, "os_drop");

        $display("[TB] independence and out-of-range select");
        applyStimulus(3'b000, 1'b1, 2'd0, 8'd1, 1'b0, "ind_cfg0");
        applyStimulus(3'b000, 1'b1, 2'd1, 8'd4, 1'b0, "ind_cfg1");
        applyStimulus(3'b011, 1'b0, 2'd0, '0, 1'b0, "indep");
        run(5, "indep");
        applyStimulus(3'b011, 1'b1, 2'd3, 8'd7, 1'b1, "bad_sel");
        run(24, "indep");

        $display("[TB] randomized traffic");
        for (int r = 0; r < 400; r++) begin
            logic [NCH-1:0] en_v;
            logic           wr_v;
            logic [1:0]     sel_v;
            logic [WIDTH-1:0] div_v;
            logic           os_v;
            en_v = en;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 15) == 0) en_v[c] = ~en_v[c];
            wr_v  = ($urandom_range(0, 5) == 0);
            sel_v = 2'($urandom_range(0, 3));
            div_v = WIDTH'($urandom_range(0, 5));
            os_v  = ($urandom_range(0, 3) == 0);
            applyStimulus(en_v, wr_v, sel_v, div_v, os_v, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
